multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that turns the existing single-cycle datapath into a multicycle core sharing one memory port for both instruction fetch and data access.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives every datapath select and enable.
- Inserts wait states on the shared memory port through a req/ready handshake.
- Suppresses writeback on signed overflow and flags illegal opcodes.

Parameters:
WAIT_W, 8, width of the memory wait-state counter
WAIT_LIMIT, 0, maximum wait cycles before bus error; 0 disables the timeout

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
op  in  6  instruction[31:26] from the instruction register
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed-overflow flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request, held until mem_ready
memwrite  out  1  write strobe, valid with mem_req
iord  out  1  0: address = pc; 1: address = aluout register
irwrite  out  1  load instruction register
pcen  out  1  PC register enable
regdst  out  1  0: rt; 1: rd
memtoreg  out  1  0: aluout; 1: memdata register
regwrite  out  1  register file write enable
alusrca  out  1  0: pc; 1: rs
alusrcb  out  2  00: rt; 01: 4; 10: signimm; 11: signimm<<2
pcsrc  out  2  00: ALU result; 01: aluout register; 10: jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  out  1  one-cycle pulse on unsupported opcode or funct
ovf_trap  out  1  one-cycle pulse when writeback is suppressed by overflow
bus_err  out  1  one-cycle pulse on wait-state timeout
state_o  out  4  current state, for debug

Behaviour:
- Reset: rst low asynchronously forces state=FETCH, ovf_q=0 and wait_cnt=0. While rst is low, all outputs are gated to 0. The first mem_req appears in the first cycle after rst deasserts.
- Outputs decode combinationally from state, op, funct and mem_ready. Any output not listed for a state is 0. pcen = pcwrite | (branch & zero).
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - When mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
  - Otherwise hold FETCH with no enables asserted.
- DECODE: alusrca=0, alusrcb=11, add (branch target captured in the aluout register). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op: illegal_op=1, go to FETCH
- MEMADR: alusrca=1, alusrcb=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready=1, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - ovf_q <= overflow & (funct is add or sub)
  - any other funct: illegal_op=1, go to FETCH with no writeback
  - otherwise -> RTYPEWB
- RTYPEWB: regdst=1, memtoreg=0, regwrite=~ovf_q; ovf_trap=ovf_q -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add; ovf_q <= overflow -> ADDIWB.
- ADDIWB: regdst=0, regwrite=~ovf_q; ovf_trap=ovf_q -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01 -> FETCH.
- JEX: pcwrite=1, pcsrc=10 -> FETCH.
- Latency with zero wait states: beq/j 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles. Each wait cycle adds 1.
- Wait counter:
  - wait_cnt increments each cycle mem_req=1 & mem_ready=0, and clears on mem_ready or on any state change.
  - If WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT-1 with mem_ready still 0: bus_err=1, wait_cnt clears.
  - In FETCH the access is retried: stay in FETCH.
  - In MEMRD/MEMWR the access is aborted: go to FETCH with no regwrite and no PC update.
  - mem_ready=1 in the same cycle as the limit wins; there is no bus_err.
- ovf_q is only sampled in RTYPEEX/ADDIEX. It clears in FETCH.
- State encoding is 4-bit binary in the order FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX=11. Unused codes go to FETCH.

Decomposition:
- Shared package holds: opcode and funct constants, state encodings, alucontrol codes, alusrcb/pcsrc select codes.
- One sub-module, alu_decoder: combinational funct -> alucontrol/valid/ovf_checked. It is reused by any future pipelined controller.

Test Plan:
- rst low mid-MEMRD, mem_ready=0 -> all outputs 0 immediately; after release, state_o=0 and mem_req=1 next cycle.
- lw (op 100011), mem_ready always 1 -> states 0,1,2,3,4, five cycles; regwrite=1 and memtoreg=1 only in MEMWB; irwrite/pcen once in FETCH.
- add with overflow=1 in RTYPEEX -> RTYPEWB has regwrite=0 and ovf_trap=1; the same add with overflow=0 -> regwrite=1, regdst=1.
- beq with zero=1 then zero=0 -> pcen=1, pcsrc=01 in the first case; pcen=0 in the second; both return to FETCH after 3 cycles.
- WAIT_LIMIT=4, mem_ready=0 in MEMWR -> bus_err pulses on the 4th wait cycle, next state FETCH, memwrite deasserts; mem_ready on exactly the 4th cycle -> no bus_err.
- op 111111 -> illegal_op pulses in DECODE, next state FETCH; funct 000111 -> illegal_op pulses in RTYPEEX with no regwrite.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Load/store share the MEMADR address-calculation step.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: ALU operation, funct legality, and whether the
// operation can raise a signed-overflow trap (add/sub only).
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       valid_o,
  output logic       ovf_checked_o
);

  // Pure lookup; unknown funct reports invalid and leaves the ALU on add.
  always_comb begin
    alucontrol_o  = ALU_ADD;
    valid_o       = 1'b1;
    ovf_checked_o = 1'b0;
    case (funct_i)
      FUNCT_ADD: begin alucontrol_o = ALU_ADD; ovf_checked_o = 1'b1; end
      FUNCT_SUB: begin alucontrol_o = ALU_SUB; ovf_checked_o = 1'b1; end
      FUNCT_AND: alucontrol_o = ALU_AND;
      FUNCT_OR:  alucontrol_o = ALU_OR;
      FUNCT_SLT: alucontrol_o = ALU_SLT;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sharing one memory port between fetch and data.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   FETCH     | read instruction at pc, pc += 4 when memory is ready
//   DECODE    | dispatch on opcode, precompute branch target
//   MEMADR    | effective address for lw/sw
//   MEMRD     | data read, waits for mem_ready
//   MEMWB     | load result into rt
//   MEMWR     | data write, waits for mem_ready
//   RTYPEEX   | R-type ALU op, capture overflow
//   RTYPEWB   | write rd unless overflow
//   BEQEX     | compare, take branch on zero
//   ADDIEX    | addi ALU op, capture overflow
//   ADDIWB    | write rt unless overflow
//   JEX       | jump
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       ovf_trap,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic              ovf_q, ovf_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       mem_req_c, memwrite_c, iord_c, irwrite_c, pcwrite_c, branch_c;
  logic       regdst_c, memtoreg_c, regwrite_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] alucontrol_c;
  logic       illegal_c, ovf_trap_c;

  logic [2:0] rt_alu;
  logic       rt_valid, rt_ovf_chk;
  logic       mem_access, limit_hit, timeout;

  alu_decoder u_alu_dec (
    .funct_i       (funct),
    .alucontrol_o  (rt_alu),
    .valid_o       (rt_valid),
    .ovf_checked_o (rt_ovf_chk)
  );

  // Kept separate from the main decode so the timeout has no path through it.
  assign mem_access = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign limit_hit  = (WAIT_LIMIT != 0) && (wait_cnt_q == LIMIT_M1);
  assign timeout    = mem_access && !mem_ready && limit_hit;

  // Per-state datapath controls and next state.
  always_comb begin
    state_d      = state_q;
    ovf_d        = ovf_q;
    mem_req_c    = 1'b0;
    memwrite_c   = 1'b0;
    iord_c       = 1'b0;
    irwrite_c    = 1'b0;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = SRCB_RT;
    pcsrc_c      = PCSRC_ALU;
    alucontrol_c = ALU_AND;
    illegal_c    = 1'b0;
    ovf_trap_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alusrcb_c    = SRCB_FOUR;
        alucontrol_c = ALU_ADD;
        ovf_d        = 1'b0;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb_c    = SRCB_IMMSH;
        alucontrol_c = ALU_ADD;
        if (is_mem_op(op))        state_d = S_MEMADR;
        else if (op == OP_RTYPE)  state_d = S_RTYPEEX;
        else if (op == OP_BEQ)    state_d = S_BEQEX;
        else if (op == OP_ADDI)   state_d = S_ADDIEX;
        else if (op == OP_J)      state_d = S_JEX;
        else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_IMM;
        alucontrol_c = ALU_ADD;
        state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = rt_alu;
        ovf_d        = overflow & rt_ovf_chk;
        if (rt_valid) state_d = S_RTYPEWB;
        else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_RTYPEWB: begin
        regdst_c   = 1'b1;
        regwrite_c = ~ovf_q;
        ovf_trap_c = ovf_q;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        branch_c     = 1'b1;
        pcsrc_c      = PCSRC_ALUOUT;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_IMM;
        alucontrol_c = ALU_ADD;
        ovf_d        = overflow;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = ~ovf_q;
        ovf_trap_c = ovf_q;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait-state counter restarts on every completed, aborted or new access.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || mem_ready || timeout)
      wait_cnt_d = '0;
    else if (mem_access)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  // State, overflow flag and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      ovf_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Everything is forced quiet while reset is held.
  assign mem_req    = rst & mem_req_c;
  assign memwrite   = rst & memwrite_c;
  assign iord       = rst & iord_c;
  assign irwrite    = rst & irwrite_c;
  assign pcen       = rst & (pcwrite_c | (branch_c & zero));
  assign regdst     = rst & regdst_c;
  assign memtoreg   = rst & memtoreg_c;
  assign regwrite   = rst & regwrite_c;
  assign alusrca    = rst & alusrca_c;
  assign alusrcb    = rst ? alusrcb_c : 2'b00;
  assign pcsrc      = rst ? pcsrc_c : 2'b00;
  assign alucontrol = rst ? alucontrol_c : 3'b000;
  assign illegal_op = rst & illegal_c;
  assign ovf_trap   = rst & ovf_trap_c;
  assign bus_err    = rst & timeout;
  assign state_o    = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each instruction's expected summary (state trace,
// strobe counts, writeback selects) is derived from the instruction rules
// and compared when the controller returns to FETCH.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, overflow, mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op, ovf_trap, bus_err;
  logic [3:0] state_o;
  logic [22:0] outs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_W(8), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .ovf_trap(ovf_trap),
    .bus_err(bus_err), .state_o(state_o)
  );

  assign outs = {mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal_op, ovf_trap, bus_err, state_o};

  typedef struct {
    bit [5:0] op;
    bit [5:0] funct;
    bit       zero;
    bit       ovf;
    int       tf;   // fetch wait cycles before memory answers
    int       td;   // data wait cycles before memory answers
  } stim_t;

  typedef struct {
    int cycles, hash, irw, pcen, pcsrc_last, regwrite, wbsel;
    int memwr, memreq, illegal, trap, buserr, alu;
    bit alu_care;
  } rec_t;

  stim_t stim_q[$];
  rec_t  exp_q[$];
  int    checks = 0, errors = 0;
  int    n_instr = 0, n_closed = 0;
  bit    sb_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input bit [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic int alu_of(input bit [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      default:   return 7;
    endcase
  endfunction

  function automatic bit op_ok(input bit [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Instruction-level reference: what one instruction should look like end to end.
  function automatic rec_t model(input stim_t s);
    int  seq[$];
    rec_t r;
    int  dcyc;
    bit  dok, ovf_eff;
    r = '{default: 0};
    r.alu_care = 1'b1;
    dok  = (s.td < 4);
    dcyc = dok ? s.td + 1 : 4;
    for (int i = 0; i <= s.tf; i++) seq.push_back(0);
    seq.push_back(1);
    r.irw    = 1;
    r.pcen   = 1;
    r.memreq = s.tf + 1;
    r.buserr = (s.tf >= 4) ? 1 : 0;
    case (s.op)
      6'b100011: begin
        seq.push_back(2);
        for (int i = 0; i < dcyc; i++) seq.push_back(3);
        r.memreq += dcyc;
        if (dok) begin seq.push_back(4); r.regwrite = 1; r.wbsel = 1; end
        else r.buserr++;
      end
      6'b101011: begin
        seq.push_back(2);
        for (int i = 0; i < dcyc; i++) seq.push_back(5);
        r.memreq += dcyc;
        r.memwr = dcyc;
        if (!dok) r.buserr++;
      end
      6'b000000: begin
        seq.push_back(6);
        if (funct_ok(s.funct)) begin
          seq.push_back(7);
          r.alu   = alu_of(s.funct);
          ovf_eff = s.ovf && (s.funct == 6'b100000 || s.funct == 6'b100010);
          if (ovf_eff) r.trap = 1;
          else begin r.regwrite = 1; r.wbsel = 2; end
        end else begin
          r.illegal  = 1;
          r.alu_care = 1'b0;
        end
      end
      6'b000100: begin
        seq.push_back(8);
        r.alu = 6;
        if (s.zero) begin r.pcen = 2; r.pcsrc_last = 1; end
      end
      6'b001000: begin
        seq.push_back(9);
        seq.push_back(10);
        if (s.ovf) r.trap = 1;
        else r.regwrite = 1;
      end
      6'b000010: begin
        seq.push_back(11);
        r.pcen = 2;
        r.pcsrc_last = 2;
      end
      default: r.illegal = 1;
    endcase
    r.cycles = seq.size();
    foreach (seq[i]) r.hash = r.hash * 13 + seq[i];
    return r;
  endfunction

  task automatic issue(input stim_t s);
    stim_q.push_back(s);
    exp_q.push_back(model(s));
    n_instr++;
  endtask

  task automatic issue_d(input bit [5:0] o, input bit [5:0] f, input bit z, input bit v,
                         input int tf, input int td);
    stim_t s;
    s.op = o; s.funct = f; s.zero = z; s.ovf = v; s.tf = tf; s.td = td;
    issue(s);
  endtask

  task automatic compare(input rec_t g);
    rec_t e;
    n_closed++;
    if (exp_q.size() == 0) begin
      chk("unexpected_instr", n_closed, n_instr);
      return;
    end
    e = exp_q.pop_front();
    chk("cycles",     g.cycles,     e.cycles);
    chk("state_trace", g.hash,      e.hash);
    chk("irwrite",    g.irw,        e.irw);
    chk("pcen",       g.pcen,       e.pcen);
    chk("pcsrc",      g.pcsrc_last, e.pcsrc_last);
    chk("regwrite",   g.regwrite,   e.regwrite);
    chk("wb_select",  g.wbsel,      e.wbsel);
    chk("memwrite",   g.memwr,      e.memwr);
    chk("mem_req",    g.memreq,     e.memreq);
    chk("illegal_op", g.illegal,    e.illegal);
    chk("ovf_trap",   g.trap,       e.trap);
    chk("bus_err",    g.buserr,     e.buserr);
    if (e.alu_care) chk("alucontrol", g.alu, e.alu);
  endtask

  // Driver and memory model: new instruction fields on each return to FETCH,
  // mem_ready after the chosen number of wait cycles of a continuous access.
  initial begin
    int    acc, prev_st;
    bit    prev_req, prev_iord, prev_ready, have;
    stim_t cur;
    acc = 0; prev_st = 15; prev_req = 0; prev_iord = 0; prev_ready = 0; have = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (state_o == 4'd0 && prev_st != 0) begin
          if (stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            have = 1;
            op = cur.op; funct = cur.funct; zero = cur.zero; overflow = cur.ovf;
          end else have = 0;
        end
        prev_st = int'(state_o);
        if (mem_req && have) begin
          if (!prev_req || iord != prev_iord || prev_ready) acc = 0;
          else acc++;
          mem_ready = (acc == (iord ? cur.td : cur.tf));
        end else mem_ready = 1'b0;
        prev_req = mem_req; prev_iord = iord; prev_ready = mem_ready;
      end
    end
  end

  // Monitor: gathers one record per instruction, FETCH to FETCH.
  initial begin
    rec_t r;
    int   st, prev_st;
    bit   open;
    r = '{default: 0};
    prev_st = 15; open = 0;
    forever begin
      @(negedge clk);
      #1;
      if (sb_en) begin
        st = int'(state_o);
        if (st == 0 && prev_st != 0) begin
          if (open) compare(r);
          r = '{default: 0};
          open = 1;
        end
        prev_st = st;
        r.cycles++;
        r.hash = r.hash * 13 + st;
        if (irwrite) r.irw++;
        if (pcen) begin r.pcen++; r.pcsrc_last = int'(pcsrc); end
        if (regwrite) begin r.regwrite++; r.wbsel = int'({regdst, memtoreg}); end
        if (memwrite) r.memwr++;
        if (mem_req) r.memreq++;
        if (illegal_op) r.illegal++;
        if (ovf_trap) r.trap++;
        if (bus_err) r.buserr++;
        if (alusrca && alusrcb == 2'b00) r.alu = int'(alucontrol);
      end
    end
  end

  initial begin
    stim_t s;
    int    k;
    rst = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;

    // Directed cases first, then random traffic.
    issue_d(6'b100011, 6'b000000, 0, 0, 0, 0);   // lw, no waits: 5 cycles
    issue_d(6'b000000, 6'b100000, 0, 1, 0, 0);   // add with overflow
    issue_d(6'b000000, 6'b100000, 0, 0, 0, 0);   // add without overflow
    issue_d(6'b000100, 6'b000000, 1, 0, 0, 0);   // beq taken
    issue_d(6'b000100, 6'b000000, 0, 0, 0, 0);   // beq not taken
    issue_d(6'b101011, 6'b000000, 0, 0, 0, 4);   // sw timeout
    issue_d(6'b101011, 6'b000000, 0, 0, 0, 3);   // sw ready on the limit cycle
    issue_d(6'b111111, 6'b000000, 0, 0, 0, 0);   // illegal opcode
    issue_d(6'b000000, 6'b000111, 0, 0, 0, 0);   // illegal funct
    issue_d(6'b001000, 6'b000000, 0, 1, 4, 0);   // addi overflow, fetch timeout+retry
    issue_d(6'b000010, 6'b000000, 0, 0, 3, 0);   // j, fetch ready on limit cycle
    issue_d(6'b100011, 6'b000000, 0, 0, 1, 5);   // lw read timeout
    for (int i = 0; i < 150; i++) begin
      s.tf = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      s.td = int'($urandom_range(0, 5));
      s.zero = 1'($urandom_range(0, 1));
      s.ovf  = 1'($urandom_range(0, 1));
      s.funct = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
              : ((k = int'($urandom_range(0, 4))) == 0) ? 6'b100000
              : (k == 1) ? 6'b100010 : (k == 2) ? 6'b100100 : (k == 3) ? 6'b100101 : 6'b101010;
      case ($urandom_range(0, 7))
        0: s.op = 6'b100011;
        1: s.op = 6'b101011;
        2, 3: s.op = 6'b000000;
        4: s.op = 6'b000100;
        5: s.op = 6'b001000;
        6: s.op = 6'b000010;
        default: begin
          s.op = 6'($urandom_range(0, 63));
          while (op_ok(s.op)) s.op = 6'($urandom_range(0, 63));
        end
      endcase
      issue(s);
    end

    // Reset behaviour: quiet outputs, immediate fetch request after release,
    // and asynchronous reset in the middle of a stalled data read.
    #12;
    chk("reset_outputs_zero", int'(outs), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("release_state", int'(state_o), 0);
    chk("release_mem_req", int'(mem_req), 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("walk_decode", int'(state_o), 1);
    @(negedge clk);
    chk("walk_memadr", int'(state_o), 2);
    @(negedge clk);
    chk("walk_memrd", int'(state_o), 3);
    chk("memrd_iord", int'(iord), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midread_reset_outputs_zero", int'(outs), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rerelease_state", int'(state_o), 0);
    chk("rerelease_mem_req", int'(mem_req), 1);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    sb_en = 1'b1;

    for (int i = 0; i < 30000 && n_closed < n_instr; i++) @(negedge clk);
    chk("instr_completed", n_closed, n_instr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
